// File: rtl/ccff_bitstream_loader_pkg.sv
// Shared types and geometry helper for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_DONE
    } ccff_ld_state_t;

    typedef struct packed {
        int unsigned words;
        int unsigned last_bits;
    } ccff_geom_t;

    // Words per pass, and how many low bits of the final word reach the chain.
    function automatic ccff_geom_t ccff_geom(input int unsigned chain_len, input int unsigned word_w);
        ccff_geom_t g;
        g.words     = (chain_len + word_w - 1) / word_w;
        g.last_bits = chain_len - word_w * (g.words - 1);
        return g;
    endfunction

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Host word handshake into the configuration-chain loader.
interface ccff_bitstream_loader_if #(
    parameter int unsigned WORD_W = 8
);
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;

    modport master (output word_valid, output word_data, input word_ready);
    modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/ccff_bitstream_loader_shift_unit.sv
// Word shift register with in-word bit counter; head_bit is the registered chain head.
module ccff_shift_unit #(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned LAST_BITS = WORD_W
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              load,
    input  logic              shift,
    input  logic              last_word,
    input  logic [WORD_W-1:0] load_data,
    output logic              head_bit,
    output logic              last_bit
);
    localparam int unsigned   BW       = $clog2(WORD_W);
    localparam logic [BW-1:0] FULL_IDX = BW'(WORD_W - 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(LAST_BITS - 1);

    logic [WORD_W-1:0] sreg;
    logic [BW-1:0]     bit_idx;

    // A load in the last-bit slot overrides the shift so the next word follows without a bubble.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            sreg    <= '0;
            bit_idx <= '0;
        end else if (load) begin
            sreg    <= load_data;
            bit_idx <= '0;
        end else if (shift) begin
            sreg    <= {1'b0, sreg[WORD_W-1:1]};
            bit_idx <= bit_idx + 1'b1;
        end
    end

    assign head_bit = sreg[0];
    assign last_bit = (bit_idx == (last_word ? LAST_IDX : FULL_IDX));
endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain head driver: host words serialized LSB-first onto ccff_head.
// Define CCFF_READBACK_EN for a two-pass load with ccff_tail readback compare.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned WORD_W    = 8
) (
    input  logic                    prog_clk,
    input  logic                    prog_reset,
    input  logic                    start,
    ccff_bitstream_loader_if.slave  host,
    output logic                    ccff_head,
    output logic                    ccff_shift_en,
    input  logic                    ccff_tail,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);
`ifdef CCFF_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    localparam ccff_geom_t      GEOM       = ccff_geom(CHAIN_LEN, WORD_W);
    localparam int unsigned     LAST_BITS  = GEOM.last_bits;
    localparam int unsigned     TW         = $clog2(CHAIN_LEN + 1);
    localparam logic [TW-1:0]   LAST_START = TW'(CHAIN_LEN - LAST_BITS);

    ccff_ld_state_t state_q, state_d;
    logic [TW-1:0]  total_cnt;
    logic           pass_q;
    logic           error_q;
    logic           shift_en_q;
    logic           ready, load, shift;
    logic           last_bit, last_word, pass_final;

    assign last_word  = (total_cnt >= LAST_START);
    assign pass_final = !READBACK || pass_q;

    ccff_shift_unit #(
        .WORD_W    (WORD_W),
        .LAST_BITS (LAST_BITS)
    ) u_shift (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .load       (load),
        .shift      (shift),
        .last_word  (last_word),
        .load_data  (host.word_data),
        .head_bit   (ccff_head),
        .last_bit   (last_bit)
    );

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_FETCH;
            ST_FETCH: begin
                ready = 1'b1;
                if (host.word_valid) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift = 1'b1;
                if (last_bit) begin
                    if (last_word) begin
                        state_d = pass_final ? ST_DONE : ST_FETCH;
                    end else begin
                        ready = 1'b1;
                        if (host.word_valid) load = 1'b1;
                        else                 state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q    <= ST_IDLE;
            total_cnt  <= '0;
            pass_q     <= 1'b0;
            error_q    <= 1'b0;
            shift_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_en_q <= (state_d == ST_SHIFT);
            if (state_q == ST_IDLE && start) begin
                total_cnt <= '0;
                pass_q    <= 1'b0;
                error_q   <= 1'b0;
            end else if (shift) begin
                if (last_bit && last_word && !pass_final) begin
                    total_cnt <= '0;
                    pass_q    <= 1'b1;
                end else begin
                    total_cnt <= total_cnt + 1'b1;
                end
                // Tail shows the previous pass's bit at the same stream position.
                if (READBACK && pass_q && (ccff_tail != ccff_head)) error_q <= 1'b1;
            end
        end
    end

    assign host.word_ready = ready;
    assign ccff_shift_en   = shift_en_q;
    assign busy            = (state_q == ST_FETCH) || (state_q == ST_SHIFT);
    assign error           = error_q;
endmodule
